// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and defaults for the matmul operand path
package matmul_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    ISSUE,
    WAIT,
    DONE
  } feeder_state_t;

  localparam int N_DEF     = 32;
  localparam int W_DEF     = 8;
  localparam int IDX_W_DEF = $clog2(N_DEF);

  // Default-size packed operand vector, element k in bits [k*W +: W]
  typedef logic [N_DEF-1:0][W_DEF-1:0] vec_t;

endpackage

// File: rtl/matmul_operand_store.sv
// rtl/matmul_operand_store.sv - A row bank and transposed B bank with full-vector reads
module matmul_operand_store
  import matmul_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           we_a,
  input  logic           we_b,
  input  logic [IW-1:0]  wr_hi,
  input  logic [IW-1:0]  wr_lo,
  input  logic [W-1:0]   wr_data,
  input  logic [IW-1:0]  rd_i,
  input  logic [IW-1:0]  rd_j,
  output logic [N*W-1:0] rd_row,
  output logic [N*W-1:0] rd_col
);

  logic [N-1:0][W-1:0] a_mem  [N];
  logic [N-1:0][W-1:0] bt_mem [N];

  // Operand banks are deliberately not reset; contents survive until overwritten.
  // B is written transposed so a column of B reads out as one register.
  always_ff @(posedge clk) begin
    if (we_a) a_mem[wr_hi][wr_lo] <= wr_data;
    if (we_b) bt_mem[wr_lo][wr_hi] <= wr_data;
  end

  assign rd_row = a_mem[rd_i];
  assign rd_col = bt_mem[rd_j];

endmodule

// File: rtl/matmul_operand_feeder.sv
// rtl/matmul_operand_feeder.sv - loads A/B from a byte stream and issues row/column pairs; FEEDER_PERF_CNT_EN adds busy_cycles
module matmul_operand_feeder
  import matmul_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axiiv,
  input  logic [W-1:0]         axiid,
  output logic                 in_ready,
  input  logic                 dp_valid,
  output logic                 axiov,
  output logic [N*W-1:0]       row1,
  output logic [N*W-1:0]       col2,
  output logic [$clog2(N)-1:0] row_idx,
  output logic [$clog2(N)-1:0] col_idx,
  output logic                 done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]          busy_cycles
`endif
);

  localparam int IW = $clog2(N);

  feeder_state_t   state;
  logic [2*IW-1:0] cnt;
  logic [IW-1:0]   i, j, i_nx, j_nx, rd_i, rd_j;
  logic [N*W-1:0]  rd_row, rd_col;
  logic            last_byte, last_pair;

  assign last_byte = (cnt == '1);
  assign last_pair = (i == IW'(N-1)) && (j == IW'(N-1));
  assign j_nx      = j + 1'b1;
  assign i_nx      = (j == IW'(N-1)) ? i + 1'b1 : i;

  // The store is read at the pair about to be issued so the operands land in
  // row1/col2 on the same edge that raises axiov (first pair is (0,0)).
  assign rd_i = (state == WAIT) ? i_nx : '0;
  assign rd_j = (state == WAIT) ? j_nx : '0;

  matmul_operand_store #(.N(N), .W(W), .IW(IW)) u_store (
    .clk     (clk),
    .we_a    ((state == LOAD_A) && axiiv),
    .we_b    ((state == LOAD_B) && axiiv),
    .wr_hi   (cnt[2*IW-1:IW]),
    .wr_lo   (cnt[IW-1:0]),
    .wr_data (axiid),
    .rd_i    (rd_i),
    .rd_j    (rd_j),
    .rd_row  (rd_row),
    .rd_col  (rd_col)
  );

  // Load / issue / wait sequencer; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      cnt      <= '0;
      i        <= '0;
      j        <= '0;
      axiov    <= 1'b0;
      done     <= 1'b0;
      row1     <= '0;
      col2     <= '0;
      row_idx  <= '0;
      col_idx  <= '0;
      in_ready <= 1'b1;
    end else begin
      axiov <= 1'b0;
      done  <= 1'b0;
      case (state)
        LOAD_A: begin
          if (axiiv) begin
            cnt <= cnt + 1'b1;
            if (last_byte) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (axiiv) begin
            cnt <= cnt + 1'b1;
            if (last_byte) begin
              state    <= ISSUE;
              in_ready <= 1'b0;
              i        <= '0;
              j        <= '0;
              row1     <= rd_row;
              col2     <= rd_col;
              row_idx  <= '0;
              col_idx  <= '0;
              axiov    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // dp_valid here belongs to no issued pair and is dropped
          state <= WAIT;
        end
        WAIT: begin
          if (dp_valid) begin
            if (last_pair) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              i       <= i_nx;
              j       <= j_nx;
              row1    <= rd_row;
              col2    <= rd_col;
              row_idx <= i_nx;
              col_idx <= j_nx;
              axiov   <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= LOAD_A;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  logic perf_run;

  // Counts cycles from the first A byte through the done cycle, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
      perf_run    <= 1'b0;
    end else if ((state == LOAD_A) && axiiv && (cnt == '0)) begin
      busy_cycles <= 32'd1;
      perf_run    <= 1'b1;
    end else if (perf_run) begin
      if (busy_cycles != '1) busy_cycles <= busy_cycles + 1'b1;
      if (state == DONE) perf_run <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// tb/tb_matmul_operand_feeder.sv - directed bench for matmul_operand_feeder at N=4, W=8
module tb_matmul_operand_feeder;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          axiiv;
  logic [W-1:0]  axiid;
  logic          in_ready;
  logic          dp_valid;
  logic          axiov;
  logic [N*W-1:0] row1, col2;
  logic [1:0]    row_idx, col_idx;
  logic          done;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]   busy_cycles;
`endif

  matmul_operand_feeder #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .in_ready (in_ready),
    .dp_valid (dp_valid),
    .axiov    (axiov),
    .row1     (row1),
    .col2     (col2),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .done     (done)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int first_cyc = 0;
  int done_cyc = 0;

  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] exp_row(input int r);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = ma[r][k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_col(input int c);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = mb[k][c];
    return v;
  endfunction

  task automatic load_mats();
    for (int b = 0; b < 2*N*N; b++) begin
      @(negedge clk);
      if (b == 0) begin
        first_cyc = cyc;
        check("in_ready_at_load", in_ready, 1);
      end
      axiiv = 1'b1;
      axiid = (b < N*N) ? ma[b/N][b%N] : mb[(b-N*N)/N][(b-N*N)%N];
    end
    @(negedge clk);
    axiiv = 1'b0;
  endtask

  // Dot-stage model answering lat cycles after each axiov; optional junk bytes
  // while not loading, optional dp_valid during the issue cycle, optional early exit.
  task automatic run_product(input int lat, input bit junk, input bit spur,
                             input int stop_at, input bit chk12);
    int pulses = 0;
    int cd = 0;
    int dp_k = -100;
    bit fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (axiov) begin
        check("row_idx", row_idx, pulses / N);
        check("col_idx", col_idx, pulses % N);
        check("row1", row1, exp_row(pulses / N));
        check("col2", col2, exp_col(pulses % N));
        if (pulses > 0) check("issue_gap", k, dp_k + 1);
        if (chk12 && pulses == 6) check("col2_at_1_2", col2, 32'h0E0A0602);
        pulses++;
        if (pulses == stop_at) begin
          dp_valid = 1'b0;
          axiiv = 1'b0;
          return;
        end
        cd = lat;
        dp_valid = spur;
      end else begin
        dp_valid = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            dp_valid = 1'b1;
            dp_k = k;
          end
        end
      end
      if (done) begin
        check("pulse_count", pulses, N*N);
        check("done_latency", k, dp_k + 1);
        done_cyc = cyc;
        fin = 1'b1;
        dp_valid = 1'b0;
        axiiv = 1'b0;
      end else begin
        axiiv = junk && !in_ready;
        axiid = 8'($urandom);
        @(negedge clk);
      end
    end
    check("done_seen", fin, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    axiiv = 1'b0;
    axiid = '0;
    dp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_axiov", axiov, 0);
    check("rst_done", done, 0);
    check("rst_row1", row1, 0);
    check("rst_col2", col2, 0);
    check("rst_idx", {row_idx, col_idx}, 0);
    rst_n = 1'b1;

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb[r][c] = 8'(4*r + c);
      end

    // basic product, 3-cycle dot stage
    load_mats();
    run_product(3, 1'b0, 1'b0, 0, 1'b1);

    // slow dot stage
    load_mats();
    run_product(20, 1'b0, 1'b0, 0, 1'b0);

    // junk bytes and stray dp_valid must not disturb anything
    load_mats();
    run_product(3, 1'b1, 1'b1, 0, 1'b1);

    // asynchronous reset while waiting on pair (2,1)
    load_mats();
    run_product(3, 1'b0, 1'b0, 2*N + 2, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_axiov", axiov, 0);
    check("arst_done", done, 0);
    check("arst_row1", row1, 0);
    check("arst_col2", col2, 0);
    check("arst_idx", {row_idx, col_idx}, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    load_mats();
    run_product(3, 1'b0, 1'b0, 0, 1'b1);

    // second matrix pair loaded immediately after done
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = 8'(8'h10 * r + c + 1);
        mb[r][c] = 8'(8'hF0 - 3 * (4*r + c));
      end
    load_mats();
    run_product(4, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("in_ready_after_done", in_ready, 1);
    check("done_one_cycle", done, 0);
`ifdef FEEDER_PERF_CNT_EN
    check("busy_cycles", busy_cycles, done_cyc - first_cyc + 1);
    repeat (3) @(negedge clk);
    check("busy_cycles_hold", busy_cycles, done_cyc - first_cyc + 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
